// File: rtl/clk3_cdc_tx.sv
// Toggle-handshake CDC transmitter: holds a 60-bit word and a toggle request until the far domain acknowledges.
// Optional acknowledge-timeout watchdog enabled by defining CLK3_CDC_TX_TIMEOUT_EN.
module clk3_cdc_tx #(
    parameter int unsigned pSTAGES  = 2,
    parameter int unsigned pTIMEOUT = 255
) (
    input  logic        clk_3,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [59:0] in_data,
    output logic        in_ready,
    output logic        tx_req,
    output logic [59:0] tx_data,
    input  logic        rx_ack,
    output logic        done,
    output logic [15:0] sent_cnt,
    input  logic        err_clr,
    output logic        timeout_err
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [pSTAGES-1:0] sync_q;
    logic               ack_s;
    logic               run_q;
    logic               accept;
    logic               complete;

    // Acknowledge synchronizer; ack_s is the only consumer-visible copy of rx_ack
    always_ff @(posedge clk_3 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[pSTAGES-2:0], rx_ack};
        end
    end

    assign ack_s = sync_q[pSTAGES-1];

    // Keeps in_ready low while reset is held; rises on the first edge after release
    always_ff @(posedge clk_3 or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign in_ready = run_q && (state_q == IDLE) && (ack_s == tx_req);

    // Next-state and handshake decode
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept  = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_s == tx_req) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_3 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tx_req   <= 1'b0;
            tx_data  <= '0;
            done     <= 1'b0;
            sent_cnt <= '0;
        end else begin
            state_q <= state_d;
            done    <= complete;
            if (accept) begin
                tx_req  <= ~tx_req;
                tx_data <= in_data;
            end
            if (complete) begin
                sent_cnt <= sent_cnt + 16'd1;
            end
        end
    end

`ifdef CLK3_CDC_TX_TIMEOUT_EN
    localparam int unsigned TO_W = (pTIMEOUT < 2) ? 1 : $clog2(pTIMEOUT + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            to_hit;

    assign to_hit = (state_q == WAIT_ACK) && (to_cnt_q == TO_W'(pTIMEOUT));

    // Counter saturates at pTIMEOUT; a simultaneous set beats err_clr
    always_ff @(posedge clk_3 or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (accept) begin
                to_cnt_q <= '0;
            end else if ((state_q == WAIT_ACK) && !to_hit) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
            if (to_hit) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end
`else
    localparam int unsigned unused_timeout = pTIMEOUT;
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_clk3_cdc_tx.sv
// Directed self-checking bench for clk3_cdc_tx (pSTAGES=2, pTIMEOUT=10).
module tb_clk3_cdc_tx;

    logic        clk_3;
    logic        rst_n;
    logic        in_valid;
    logic [59:0] in_data;
    logic        in_ready;
    logic        tx_req;
    logic [59:0] tx_data;
    logic        rx_ack;
    logic        done;
    logic [15:0] sent_cnt;
    logic        err_clr;
    logic        timeout_err;

    logic ack_reg;
    logic echo_dly;
    logic echo_comb;
    int   checks;
    int   errors;

    clk3_cdc_tx #(.pSTAGES(2), .pTIMEOUT(10)) dut (
        .clk_3      (clk_3),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .tx_req     (tx_req),
        .tx_data    (tx_data),
        .rx_ack     (rx_ack),
        .done       (done),
        .sent_cnt   (sent_cnt),
        .err_clr    (err_clr),
        .timeout_err(timeout_err)
    );

    // Far-domain model: either a one-cycle echo or a combinational echo of tx_req
    assign rx_ack = echo_comb ? tx_req : ack_reg;

    always @(posedge clk_3) begin
        if (echo_dly) ack_reg <= tx_req;
    end

    initial begin
        clk_3 = 1'b0;
        forever #5 clk_3 = ~clk_3;
    end

    task automatic tick();
        @(posedge clk_3);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; err_clr = 1'b0;
        ack_reg = 1'b0; echo_dly = 1'b0; echo_comb = 1'b0;
        tick(); tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL reset_tx_req got %b want 0", tx_req); end
        checks++; if (tx_data !== 60'h0) begin errors++; $display("FAIL reset_tx_data got %h want 0", tx_data); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (sent_cnt !== 16'h0) begin errors++; $display("FAIL reset_sent_cnt got %h want 0", sent_cnt); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        int n_done;
        int done_at;
        n_done = 0; done_at = -1;
        echo_dly = 1'b1;
        in_valid = 1'b1; in_data = 60'hABC_DEF0_1234_567;
        tick();
        in_valid = 1'b0; in_data = '0;
        checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL basic_tx_req got %b want 1", tx_req); end
        checks++; if (tx_data !== 60'hABC_DEF0_1234_567) begin errors++; $display("FAIL basic_tx_data got %h want abcdef01234567", tx_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy_in_ready got %b want 0", in_ready); end
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (done === 1'b1) begin n_done++; if (done_at < 0) done_at = i; end
        end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", n_done); end
        checks++; if (done_at !== 4) begin errors++; $display("FAIL basic_done_cycle got %0d want 4", done_at); end
        checks++; if (sent_cnt !== 16'd1) begin errors++; $display("FAIL basic_sent_cnt got %0d want 1", sent_cnt); end
        checks++; if (tx_data !== 60'hABC_DEF0_1234_567) begin errors++; $display("FAIL basic_idle_tx_data got %h want abcdef01234567", tx_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_idle_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_hold();
        logic got_done;
        got_done = 1'b0;
        in_valid = 1'b1; in_data = 60'h111_2222_3333_4444;
        tick();
        for (int i = 1; i <= 10; i++) begin
            in_data = 60'h0F0_0000_0000_0000 + 60'(i);
            tick();
            if (done === 1'b1) begin
                got_done = 1'b1;
                in_valid = 1'b0;
                break;
            end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc %0d got %b want 0", i, in_ready); end
            checks++; if (tx_data !== 60'h111_2222_3333_4444) begin errors++; $display("FAIL hold_tx_data cyc %0d got %h want 111222233334444", i, tx_data); end
        end
        in_valid = 1'b0;
        checks++; if (got_done !== 1'b1) begin errors++; $display("FAIL hold_done_timeout got %b want 1", got_done); end
        checks++; if (tx_data !== 60'h111_2222_3333_4444) begin errors++; $display("FAIL hold_done_tx_data got %h want 111222233334444", tx_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_after_in_ready got %b want 1", in_ready); end
        checks++; if (sent_cnt !== 16'd2) begin errors++; $display("FAIL hold_sent_cnt got %0d want 2", sent_cnt); end
        tick();
    endtask

    task automatic test_idle_ack();
        int n_done;
        logic req0;
        n_done = 0;
        req0 = tx_req;
        echo_dly = 1'b0;
        ack_reg = ~ack_reg;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_ack_in_ready got %b want 0", in_ready); end
        ack_reg = ~ack_reg;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_ack_restored_in_ready got %b want 1", in_ready); end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL idle_ack_done_count got %0d want 0", n_done); end
        checks++; if (sent_cnt !== 16'd2) begin errors++; $display("FAIL idle_ack_sent_cnt got %0d want 2", sent_cnt); end
        checks++; if (tx_req !== req0) begin errors++; $display("FAIL idle_ack_tx_req got %b want %b", tx_req, req0); end
    endtask

    task automatic test_back_to_back();
        int  accepts;
        int  dones;
        int  cyc;
        int  first_acc;
        int  first_done;
        logic acc_now;
        accepts = 0; dones = 0; cyc = 0; first_acc = -1; first_done = -1;
        in_valid = 1'b0; echo_dly = 1'b0; echo_comb = 1'b0; ack_reg = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        echo_comb = 1'b1;
        in_valid = 1'b1;
        while (dones < 65536 && cyc < 65536 * 4 + 100) begin
            if (accepts == 65536) in_valid = 1'b0;
            in_data = 60'(accepts);
            acc_now = in_valid && in_ready;
            tick();
            cyc++;
            if (acc_now) begin
                accepts++;
                if (first_acc < 0) first_acc = cyc;
            end
            if (done === 1'b1) begin
                dones++;
                if (first_done < 0) first_done = cyc;
                if (dones == 65535) begin
                    checks++; if (sent_cnt !== 16'hFFFF) begin errors++; $display("FAIL b2b_sent_cnt_max got %h want ffff", sent_cnt); end
                    checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL b2b_parity_odd got %b want 1", tx_req); end
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (dones !== 65536) begin errors++; $display("FAIL b2b_done_count got %0d want 65536", dones); end
        checks++; if (first_done - first_acc !== 3) begin errors++; $display("FAIL b2b_latency got %0d want 3", first_done - first_acc); end
        checks++; if (sent_cnt !== 16'h0000) begin errors++; $display("FAIL b2b_sent_cnt_wrap got %h want 0000", sent_cnt); end
        checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL b2b_parity got %b want 0", tx_req); end
        checks++; if (tx_data !== 60'd65535) begin errors++; $display("FAIL b2b_last_data got %h want ffff", tx_data); end
        tick();
        ack_reg = tx_req;
        echo_comb = 1'b0;
    endtask

`ifdef CLK3_CDC_TX_TIMEOUT_EN
    task automatic test_timeout();
        logic got_done;
        got_done = 1'b0;
        in_valid = 1'b1; in_data = 60'h5A5;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", timeout_err); end
        tick(); tick();
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_set got %b want 1", timeout_err); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL to_still_waiting got %b want 0", in_ready); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_set_wins got %b want 1", timeout_err); end
        ack_reg = tx_req;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) begin got_done = 1'b1; break; end
        end
        checks++; if (got_done !== 1'b1) begin errors++; $display("FAIL to_late_done got %b want 1", got_done); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", timeout_err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear got %b want 0", timeout_err); end
    endtask
`else
    task automatic test_timeout();
        logic got_done;
        got_done = 1'b0;
        in_valid = 1'b1; in_data = 60'h5A5;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_disabled got %b want 0", timeout_err); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL to_disabled_waiting got %b want 0", in_ready); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        ack_reg = tx_req;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) begin got_done = 1'b1; break; end
        end
        checks++; if (got_done !== 1'b1) begin errors++; $display("FAIL to_disabled_done got %b want 1", got_done); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_disabled_after got %b want 0", timeout_err); end
    endtask
`endif

    task automatic test_reset_mid();
        int n_done;
        n_done = 0;
        tick();
        in_valid = 1'b1; in_data = 60'hFED_CBA9_8765_432;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (tx_req !== ~ack_reg) begin errors++; $display("FAIL rst_mid_pending got %b want %b", tx_req, ~ack_reg); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready got %b want 0", in_ready); end
        checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL rst_mid_tx_req got %b want 0", tx_req); end
        checks++; if (tx_data !== 60'h0) begin errors++; $display("FAIL rst_mid_tx_data got %h want 0", tx_data); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b want 0", done); end
        checks++; if (sent_cnt !== 16'h0) begin errors++; $display("FAIL rst_mid_sent_cnt got %h want 0", sent_cnt); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_mid_timeout_err got %b want 0", timeout_err); end
        ack_reg = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL rst_mid_done_count got %0d want 0", n_done); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_release_in_ready got %b want 1", in_ready); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_hold();
        test_idle_ack();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
